bus_arbit: RTL and testbench
============================

BUS_ARBIT -- requirements
Module: bus_arbit

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of write and read data buses.
REQ-002 SHALL have parameter MAX_HOLD, default 16, the cycles a grantee may hold the bus while the other master waits; range 2..255.
REQ-003 SHALL have port clk, input, 1, the single clock; every register is updated on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have ports M0_req / M1_req, input, 1, bus request from master 0 / 1.
REQ-006 SHALL have ports M0_wr / M1_wr, input, 1, write enable from master 0 / 1; 0 means read.
REQ-007 SHALL have ports M0_addr / M1_addr, input, 8, address from master 0 / 1.
REQ-008 SHALL have ports M0_dout / M1_dout, input, DATA_W, write data from master 0 / 1.
REQ-009 SHALL have ports M0_grant / M1_grant, output, 1, grant to master 0 / 1; exactly one is high at all times.
REQ-010 SHALL have port M_addr, output, 8, the selected master's address; it drives the address decoder and the slaves.
REQ-011 SHALL have port M_wr, output, 1, the selected write strobe.
REQ-012 SHALL have port M_dout, output, DATA_W, the selected write data.
REQ-013 SHALL have ports S0_sel..S3_sel, input, 1 each, one-hot slave selects from the address decoder.
REQ-014 SHALL have ports S0_dout..S3_dout, input, DATA_W each, read data from slaves 0..3.
REQ-015 SHALL have port M_din, output, DATA_W, read data returned to both masters.

Function
REQ-016 SHALL implement a two-state Moore FSM, GNT_M0 / GNT_M1, with M0_grant = (state==GNT_M0) and M1_grant = (state==GNT_M1).
REQ-017 In GNT_M0, the FSM SHALL move to GNT_M1 if (!M0_req && M1_req), or if (M1_req && hold_cnt==MAX_HOLD-1); otherwise it SHALL stay.
REQ-018 In GNT_M1, the FSM SHALL move to GNT_M0 if !M1_req, or if (M0_req && hold_cnt==MAX_HOLD-1); otherwise it SHALL stay.
REQ-019 hold_cnt SHALL increment each cycle in which the grantee's req is high, the other req is high, and the state does not change; it SHALL clear to 0 on any state change and in any cycle where the other req is low.
REQ-020 hold_cnt SHALL never exceed MAX_HOLD-1 and SHALL use ceil(log2(MAX_HOLD)) bits.
REQ-021 M_addr and M_dout SHALL be combinational copies of the granted master's addr and dout, with zero added latency.
REQ-022 M_wr SHALL equal the granted master's (req & wr); a non-requesting grantee SHALL never cause a write.
REQ-023 A grant change SHALL take effect on the clock edge after the deciding cycle; the granted master's request is serviced in the first cycle its grant is high.
REQ-024 Slaves return read data one cycle after the address, so {S0_sel..S3_sel} SHALL be registered every cycle into sel_q.
REQ-025 M_din SHALL be the Sn_dout chosen by sel_q.
REQ-026 M_din SHALL be all zeros when sel_q == 4'b0000 (unmapped address 8'h60..8'hFF).
REQ-027 A non-one-hot sel_q SHALL also give all zeros; this case SHALL never occur in a legal system.
REQ-028 When both requests rise in the same cycle, the master currently holding the grant SHALL keep it.

Reset
REQ-029 When reset is high at a rising edge, the block SHALL set state=GNT_M0, hold_cnt=0 and sel_q=4'b0000.
REQ-030 After that edge, M0_grant SHALL be 1, M1_grant 0 and M_din 0.
REQ-031 Reset asserted mid-transfer or mid-hold SHALL abandon the transfer, with no partial-state carryover.
REQ-032 While reset is high, M_wr SHALL follow REQ-022 under GNT_M0; masters SHALL hold req low during reset.

Structure
REQ-033 The FSM state encodings (GNT_M0=1'b0, GNT_M1=1'b1) and the address-map nibble constants SHALL live in the shared bus definitions include file, which the address decoder also uses.
REQ-034 The read-return path (the sel_q register plus the 4:1 zero-default mux) SHALL be a sub-module, bus_rd_mux, instantiated once.
REQ-035 The total RTL SHALL be 120-400 lines.

Verification
REQ-036 Scenario 1: hold reset for 2 cycles, then release with no requests -> M0_grant=1, M1_grant=0, M_din=0, M_wr=0.
REQ-037 Scenario 2: only M1_req=1, M1_wr=1, M1_addr=8'h12, M1_dout=32'hA5A5_0001 -> M1_grant=1 from the next edge, then M_addr=8'h12 and M_wr=1 while granted.
REQ-038 Scenario 3: M0 holds req for 40 cycles while M1 also requests, MAX_HOLD=16 -> the grant alternates every 16 cycles; neither master waits more than 17 cycles.
REQ-039 Scenario 4: M0 reads 8'h05, 8'h15, 8'h35, 8'h45, 8'h70 on back-to-back cycles with S0..S3_dout = 32'h0000_00A0..32'h0000_00A3 -> M_din one cycle later is A0, A1, A2, A3, then 0.
REQ-040 Scenario 5: both requests rise in the same cycle while in GNT_M1 -> M1 keeps the grant; assert reset during that transfer -> the next cycle shows GNT_M0, sel_q=0, M_din=0.

Source files
------------

// File: rtl/bus_arbit_pkg.sv
// Shared bus definitions: grant FSM encoding and the slave address map.
// The arbiter and the external address decoder both import this package.
package bus_arbit_pkg;

    // Grant FSM state; the encoding is fixed so external observers can decode it.
    typedef enum logic {
        GntM0 = 1'b0,
        GntM1 = 1'b1
    } gnt_state_e;

    localparam int unsigned NumSlaves = 4;

    // Address map by upper nibble; 8'h60..8'hFF is unmapped.
    localparam logic [3:0] Slv0Nib   = 4'h0;
    localparam logic [3:0] Slv1NibLo = 4'h1;
    localparam logic [3:0] Slv1NibHi = 4'h2;
    localparam logic [3:0] Slv2Nib   = 4'h3;
    localparam logic [3:0] Slv3NibLo = 4'h4;
    localparam logic [3:0] Slv3NibHi = 4'h5;

    // One-hot slave select for an address; all zeros when unmapped.
    function automatic logic [NumSlaves-1:0] addr_decode(logic [7:0] addr);
        logic [NumSlaves-1:0] sel;
        sel = '0;
        unique case (addr[7:4])
            Slv0Nib:              sel = 4'b0001;
            Slv1NibLo, Slv1NibHi: sel = 4'b0010;
            Slv2Nib:              sel = 4'b0100;
            Slv3NibLo, Slv3NibHi: sel = 4'b1000;
            default:              sel = 4'b0000;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/bus_arbit_if.sv
// Two-master shared bus: master request side, muxed bus, decoder selects and slave data.
interface bus_arbit_if #(
    parameter int unsigned DATA_W = 32
);
    logic              M0_req;
    logic              M1_req;
    logic              M0_wr;
    logic              M1_wr;
    logic [7:0]        M0_addr;
    logic [7:0]        M1_addr;
    logic [DATA_W-1:0] M0_dout;
    logic [DATA_W-1:0] M1_dout;
    logic              M0_grant;
    logic              M1_grant;
    logic [7:0]        M_addr;
    logic              M_wr;
    logic [DATA_W-1:0] M_dout;
    logic              S0_sel;
    logic              S1_sel;
    logic              S2_sel;
    logic              S3_sel;
    logic [DATA_W-1:0] S0_dout;
    logic [DATA_W-1:0] S1_dout;
    logic [DATA_W-1:0] S2_dout;
    logic [DATA_W-1:0] S3_dout;
    logic [DATA_W-1:0] M_din;

    // Arbiter view: takes master requests and slave data, drives grants and the shared bus.
    modport slave (
        input  M0_req, M1_req, M0_wr, M1_wr, M0_addr, M1_addr, M0_dout, M1_dout,
        input  S0_sel, S1_sel, S2_sel, S3_sel, S0_dout, S1_dout, S2_dout, S3_dout,
        output M0_grant, M1_grant, M_addr, M_wr, M_dout, M_din
    );

    // Environment view: masters, address decoder and slaves.
    modport master (
        output M0_req, M1_req, M0_wr, M1_wr, M0_addr, M1_addr, M0_dout, M1_dout,
        output S0_sel, S1_sel, S2_sel, S3_sel, S0_dout, S1_dout, S2_dout, S3_dout,
        input  M0_grant, M1_grant, M_addr, M_wr, M_dout, M_din
    );
endinterface

// File: rtl/bus_rd_mux.sv
// Read-return path: slaves answer one cycle after the address, so the decoder
// selects are registered and steer the matching slave data back to the masters.
module bus_rd_mux #(
    parameter int unsigned DataW = 32
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [3:0]       sel_i,
    input  logic [DataW-1:0] s0_dout_i,
    input  logic [DataW-1:0] s1_dout_i,
    input  logic [DataW-1:0] s2_dout_i,
    input  logic [DataW-1:0] s3_dout_i,
    output logic [DataW-1:0] din_o
);
    logic [3:0] sel_q;

    // Capture the selects every cycle to align with the slave read latency.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sel_q <= 4'b0000;
        end else begin
            sel_q <= sel_i;
        end
    end

    // Zero-default mux: unmapped (no select) or a corrupt multi-hot select reads as zero.
    always_comb begin
        din_o = '0;
        unique case (sel_q)
            4'b0001: din_o = s0_dout_i;
            4'b0010: din_o = s1_dout_i;
            4'b0100: din_o = s2_dout_i;
            4'b1000: din_o = s3_dout_i;
            default: din_o = '0;
        endcase
    end
endmodule

// File: rtl/bus_arbit.sv
// Two-master bus arbiter. Grant is a registered Moore FSM with a bounded hold
// time so neither master starves; the bus itself is muxed combinationally.
module bus_arbit
    import bus_arbit_pkg::*;
#(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic         clk,
    input  logic         reset,
    bus_arbit_if.slave   bus
);
    localparam int unsigned     HoldW    = $clog2(MAX_HOLD);
    localparam logic [HoldW-1:0] HoldLast = HoldW'(MAX_HOLD - 1);

    gnt_state_e       state_q, state_d;
    logic [HoldW-1:0] hold_q, hold_d;
    logic             own_req;
    logic             oth_req;
    logic             hold_expired;
    logic             switch_gnt;

    // Next-state and hold counter: count only while both contend and the grant stays put.
    always_comb begin
        own_req      = (state_q == GntM1) ? bus.M1_req : bus.M0_req;
        oth_req      = (state_q == GntM1) ? bus.M0_req : bus.M1_req;
        hold_expired = (hold_q == HoldLast);
        switch_gnt   = 1'b0;
        unique case (state_q)
            GntM0: switch_gnt = (!bus.M0_req && bus.M1_req) || (bus.M1_req && hold_expired);
            GntM1: switch_gnt = !bus.M1_req || (bus.M0_req && hold_expired);
            default: switch_gnt = 1'b0;
        endcase

        state_d = state_q;
        if (switch_gnt) begin
            state_d = (state_q == GntM0) ? GntM1 : GntM0;
        end

        hold_d = '0;
        if (!switch_gnt && own_req && oth_req) begin
            hold_d = hold_q + HoldW'(1);
        end
    end

    // Grant FSM state and hold counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= GntM0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

    assign bus.M0_grant = (state_q == GntM0);
    assign bus.M1_grant = (state_q == GntM1);

    // Zero-latency bus mux; a grantee that is not requesting never strobes a write.
    always_comb begin
        bus.M_addr = bus.M0_addr;
        bus.M_dout = bus.M0_dout;
        bus.M_wr   = bus.M0_req & bus.M0_wr;
        if (state_q == GntM1) begin
            bus.M_addr = bus.M1_addr;
            bus.M_dout = bus.M1_dout;
            bus.M_wr   = bus.M1_req & bus.M1_wr;
        end
    end

    bus_rd_mux #(
        .DataW (DATA_W)
    ) u_rd_mux (
        .clk_i     (clk),
        .reset_i   (reset),
        .sel_i     ({bus.S3_sel, bus.S2_sel, bus.S1_sel, bus.S0_sel}),
        .s0_dout_i (bus.S0_dout),
        .s1_dout_i (bus.S1_dout),
        .s2_dout_i (bus.S2_dout),
        .s3_dout_i (bus.S3_dout),
        .din_o     (bus.M_din)
    );
endmodule

// File: tb/tb_bus_arbit.sv
// Bench for bus_arbit: directed cycles push expected bus state into a queue,
// a negedge monitor pops one entry per cycle and compares.
module tb_bus_arbit;
    import bus_arbit_pkg::*;

    localparam int unsigned DataW   = 32;
    localparam int unsigned MaxHold = 16;

    bit   clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    bus_arbit_if #(.DATA_W(DataW)) bus ();

    bus_arbit #(
        .DATA_W   (DataW),
        .MAX_HOLD (MaxHold)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Address decoder with an override for injecting illegal selects; fixed slave data.
    logic       sel_ovr_en;
    logic [3:0] sel_ovr;
    logic [3:0] dec_sel;
    always_comb dec_sel = sel_ovr_en ? sel_ovr : addr_decode(bus.M_addr);
    assign bus.S0_sel  = dec_sel[0];
    assign bus.S1_sel  = dec_sel[1];
    assign bus.S2_sel  = dec_sel[2];
    assign bus.S3_sel  = dec_sel[3];
    assign bus.S0_dout = 32'h0000_00A0;
    assign bus.S1_dout = 32'h0000_00A1;
    assign bus.S2_dout = 32'h0000_00A2;
    assign bus.S3_dout = 32'h0000_00A3;

    typedef struct {
        string       tag;
        bit          chk_gnt;
        bit          m1;
        bit          chk_bus;
        logic [7:0]  addr;
        logic        wr;
        logic [31:0] dout;
        bit          chk_din;
        logic [31:0] din;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(string tag, string what, logic [31:0] act, logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s.%s: got %h, required %h", tag, what, act, req);
        end
    endtask

    function automatic void exp_push(string tag, bit chk_gnt, bit m1, bit chk_bus,
                                     logic [7:0] addr, logic wr, logic [31:0] dout,
                                     bit chk_din, logic [31:0] din);
        exp_t e;
        e.tag     = tag;
        e.chk_gnt = chk_gnt;
        e.m1      = m1;
        e.chk_bus = chk_bus;
        e.addr    = addr;
        e.wr      = wr;
        e.dout    = dout;
        e.chk_din = chk_din;
        e.din     = din;
        exp_q.push_back(e);
    endfunction

    // Apply one cycle of inputs shortly after the rising edge.
    task automatic cyc(bit rst, bit r0, bit w0, logic [7:0] a0, logic [31:0] d0,
                       bit r1, bit w1, logic [7:0] a1, logic [31:0] d1);
        @(posedge clk);
        #1;
        reset       = rst;
        bus.M0_req  = r0;
        bus.M0_wr   = w0;
        bus.M0_addr = a0;
        bus.M0_dout = d0;
        bus.M1_req  = r1;
        bus.M1_wr   = w1;
        bus.M1_addr = a1;
        bus.M1_dout = d1;
    endtask

    // Monitor: one expectation per cycle, sampled mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e.chk_gnt) begin
                check(e.tag, "grant", {30'b0, bus.M1_grant, bus.M0_grant},
                      e.m1 ? 32'd2 : 32'd1);
            end
            if (e.chk_bus) begin
                check(e.tag, "M_addr", {24'b0, bus.M_addr}, {24'b0, e.addr});
                check(e.tag, "M_wr", {31'b0, bus.M_wr}, {31'b0, e.wr});
                check(e.tag, "M_dout", bus.M_dout, e.dout);
            end
            if (e.chk_din) begin
                check(e.tag, "M_din", bus.M_din, e.din);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  rd_addr [5];
        logic [31:0] rd_din  [5];
        rd_addr = '{8'h05, 8'h15, 8'h35, 8'h45, 8'h70};
        rd_din  = '{32'h0, 32'hA0, 32'hA1, 32'hA2, 32'hA3};

        reset       = 1'b1;
        sel_ovr_en  = 1'b0;
        sel_ovr     = 4'b0000;
        bus.M0_req  = 1'b0;
        bus.M0_wr   = 1'b0;
        bus.M0_addr = 8'h00;
        bus.M0_dout = 32'h0;
        bus.M1_req  = 1'b0;
        bus.M1_wr   = 1'b0;
        bus.M1_addr = 8'h00;
        bus.M1_dout = 32'h0;

        // Scenario 1: two reset cycles, then idle.
        cyc(1, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0);
        exp_push("rst_hold", 1, 0, 1, 8'h00, 0, 0, 1, 0);
        cyc(0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0);
        exp_push("idle", 1, 0, 1, 8'h00, 0, 0, 1, 0);

        // Scenario 2: M1 alone requests a write.
        cyc(0, 0, 0, 8'h00, 0, 1, 1, 8'h12, 32'hA5A5_0001);
        exp_push("m1_req", 1, 0, 1, 8'h00, 0, 0, 0, 0);
        cyc(0, 0, 0, 8'h00, 0, 1, 1, 8'h12, 32'hA5A5_0001);
        exp_push("m1_gnt", 1, 1, 1, 8'h12, 1, 32'hA5A5_0001, 0, 0);
        cyc(0, 0, 0, 8'h00, 0, 1, 1, 8'h12, 32'hA5A5_0001);
        exp_push("m1_stay", 1, 1, 1, 8'h12, 1, 32'hA5A5_0001, 0, 0);
        // Grantee drops req with wr still high: no write, grant returns next edge.
        cyc(0, 0, 0, 8'h00, 0, 0, 1, 8'h12, 32'hA5A5_0001);
        exp_push("m1_drop", 1, 1, 1, 8'h12, 0, 32'hA5A5_0001, 0, 0);
        cyc(0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0);
        exp_push("back_m0", 1, 0, 1, 8'h00, 0, 0, 0, 0);

        // Scenario 4: back-to-back reads, data returns one cycle later.
        for (int i = 0; i < 5; i++) begin
            cyc(0, 1, 0, rd_addr[i], 0, 0, 0, 8'h00, 0);
            exp_push($sformatf("rd%0d", i), 1, 0, 1, rd_addr[i], 0, 0, i > 0, rd_din[i]);
        end
        cyc(0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0);
        sel_ovr_en = 1'b1;
        sel_ovr    = 4'b0011;
        exp_push("rd_unmapped", 1, 0, 1, 8'h00, 0, 0, 1, 32'h0);
        cyc(0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0);
        sel_ovr_en = 1'b0;
        exp_push("rd_multihot", 1, 0, 0, 8'h00, 0, 0, 1, 32'h0);
        cyc(0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0);
        exp_push("rd_idle_s0", 1, 0, 0, 8'h00, 0, 0, 1, 32'hA0);

        // Scenario 3: both contend for 40 cycles; grant flips every MaxHold cycles.
        for (int k = 0; k < 40; k++) begin
            bit m1;
            m1 = ((k / MaxHold) % 2) == 1;
            cyc(0, 1, 0, 8'h01, 0, 1, 0, 8'h11, 0);
            exp_push($sformatf("hold%0d", k), 1, m1, 1, m1 ? 8'h11 : 8'h01, 0, 0, 0, 0);
        end
        cyc(0, 0, 0, 8'h01, 0, 1, 0, 8'h11, 0);
        exp_push("m0_release", 1, 0, 1, 8'h01, 0, 0, 0, 0);

        // Scenario 5: contention while M1 holds, then reset mid-transfer.
        cyc(0, 0, 0, 8'h01, 0, 1, 0, 8'h11, 0);
        exp_push("m1_alone", 1, 1, 1, 8'h11, 0, 0, 0, 0);
        cyc(0, 1, 1, 8'h01, 32'h0000_0B0B, 1, 1, 8'h22, 32'hDEAD_0005);
        exp_push("both_req", 1, 1, 1, 8'h22, 1, 32'hDEAD_0005, 0, 0);
        cyc(0, 1, 1, 8'h01, 32'h0000_0B0B, 1, 1, 8'h22, 32'hDEAD_0005);
        exp_push("both_keep", 1, 1, 1, 8'h22, 1, 32'hDEAD_0005, 1, 32'hA1);
        cyc(1, 0, 0, 8'h01, 0, 0, 0, 8'h22, 0);
        exp_push("rst_mid", 1, 1, 1, 8'h22, 0, 0, 1, 32'hA1);
        cyc(0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0);
        exp_push("post_rst", 1, 0, 1, 8'h00, 0, 0, 1, 32'h0);
        cyc(0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0);
        exp_push("post_rst2", 1, 0, 0, 8'h00, 0, 0, 1, 32'hA0);

        repeat (3) @(negedge clk);
        #1;
        check("drain", "pending", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
